multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/riscv_ctrl_pkg.sv | 55 +++++
 rtl/opcode_class_decode.sv | 30 +++
 rtl/multicycle_control.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared state, opcode and select encodings for the multicycle control FSM
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_WB_ALU   = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10,
    ST_JALR     = 4'd11,
    ST_TRAP     = 4'd12
  } state_t;

  typedef enum logic [3:0] {
    CLS_R, CLS_IMM, CLS_LUI, CLS_LOAD, CLS_STORE,
    CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_ILLEGAL
  } op_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_RFN = 2'b10;
  localparam logic [1:0] ALUOP_IFN = 2'b11;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

  localparam logic [1:0] SRCA_PC   = 2'd0;
  localparam logic [1:0] SRCA_RS1  = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JALR   = 2'd2;

endpackage

// File: rtl/opcode_class_decode.sv
// rtl/opcode_class_decode.sv - combinational opcode to instruction-class map with illegal flag
module opcode_class_decode
  import riscv_ctrl_pkg::*;
#(
  parameter int SUPPORT_IMM  = 1,
  parameter int SUPPORT_JUMP = 1
) (
  input  logic [6:0] i_opcode,
  output op_class_t  o_cls,
  output logic       o_illegal
);

  always_comb begin
    o_cls = CLS_ILLEGAL;
    case (i_opcode)
      OP_R:      o_cls = CLS_R;
      OP_IMM:    if (SUPPORT_IMM != 0) o_cls = CLS_IMM;
      OP_LUI:    if (SUPPORT_IMM != 0) o_cls = CLS_LUI;
      OP_LOAD:   o_cls = CLS_LOAD;
      OP_STORE:  o_cls = CLS_STORE;
      OP_BRANCH: o_cls = CLS_BRANCH;
      OP_JAL:    if (SUPPORT_JUMP != 0) o_cls = CLS_JAL;
      OP_JALR:   if (SUPPORT_JUMP != 0) o_cls = CLS_JALR;
      default:   o_cls = CLS_ILLEGAL;
    endcase
  end

  assign o_illegal = (o_cls == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RISC-V control FSM with memory wait timeout and sticky faults
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int SUPPORT_IMM  = 1,
  parameter int SUPPORT_JUMP = 1,
  parameter int MEM_TIMEOUT  = 0,
  parameter int TW           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [3:0] state,
  output logic       illegal,
  output logic       timeout
);

  localparam logic [TW-1:0] L_TIMEOUT = TW'(MEM_TIMEOUT);
  localparam bit            L_TO_EN   = (MEM_TIMEOUT > 0);

  state_t        r_state, w_next;
  op_class_t     r_cls, w_cls;
  logic          w_dec_illegal;
  logic [TW-1:0] r_cnt, w_cnt_inc;
  logic          r_illegal, r_timeout;
  logic          w_wait_state, w_timeout_hit, w_enter_wait;

  opcode_class_decode #(
    .SUPPORT_IMM (SUPPORT_IMM),
    .SUPPORT_JUMP(SUPPORT_JUMP)
  ) u_dec (
    .i_opcode (opcode),
    .o_cls    (w_cls),
    .o_illegal(w_dec_illegal)
  );

  assign w_wait_state  = (r_state == ST_FETCH) || (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);
  assign w_cnt_inc     = r_cnt + TW'(1);
  // Trap on the waiting cycle that would carry the counter onto the limit.
  assign w_timeout_hit = L_TO_EN && w_wait_state && !mem_ready && (w_cnt_inc == L_TIMEOUT);
  assign w_enter_wait  = (w_next != r_state) &&
                         ((w_next == ST_FETCH) || (w_next == ST_MEM_RD) || (w_next == ST_MEM_WR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_cls     <= CLS_ILLEGAL;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_enter_wait)
        r_cnt <= '0;
      else if (w_wait_state && !mem_ready && (r_cnt != L_TIMEOUT))
        r_cnt <= w_cnt_inc;
      if (r_state == ST_DECODE) r_cls <= w_cls;
      if ((r_state == ST_DECODE) && w_dec_illegal) r_illegal <= 1'b1;
      if (w_timeout_hit) r_timeout <= 1'b1;
    end
  end

  always_comb begin
    w_next        = r_state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = WB_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    pc_src        = PCSRC_ALU;
    reg_write     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = ST_DECODE;
        end else if (w_timeout_hit) begin
          w_next = ST_TRAP;
        end
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM;
        case (w_cls)
          CLS_R:               w_next = ST_EXEC_R;
          CLS_IMM, CLS_LUI:    w_next = ST_EXEC_I;
          CLS_LOAD, CLS_STORE: w_next = ST_MEM_ADDR;
          CLS_BRANCH:          w_next = ST_BRANCH;
          CLS_JAL:             w_next = ST_JUMP;
          CLS_JALR:            w_next = ST_JALR;
          default:             w_next = ST_TRAP;
        endcase
      end
      ST_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_RFN;
        w_next    = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        alu_src_a = (r_cls == CLS_LUI) ? SRCA_ZERO : SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_IFN;
        w_next    = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        reg_write = 1'b1;
        w_next    = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_next    = (r_cls == CLS_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready)          w_next = ST_WB_MEM;
        else if (w_timeout_hit) w_next = ST_TRAP;
      end
      ST_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready)          w_next = ST_FETCH;
        else if (w_timeout_hit) w_next = ST_TRAP;
      end
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_MDR;
        w_next     = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a     = SRCA_RS1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_ALUOUT;
        w_next        = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PCSRC_ALUOUT;
        reg_write  = 1'b1;
        mem_to_reg = WB_PC4;
        w_next     = ST_FETCH;
      end
      ST_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        pc_write   = 1'b1;
        pc_src     = PCSRC_JALR;
        reg_write  = 1'b1;
        mem_to_reg = WB_PC4;
        w_next     = ST_FETCH;
      end
      default: w_next = ST_TRAP;
    endcase
    // Reset must silence every strobe immediately, not one edge later.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      alu_src_b = SRCB_RS2;
    end
  end

  assign state   = r_state;
  assign illegal = r_illegal;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed scoreboard bench for multicycle_control
module tb_multicycle_control;
  import riscv_ctrl_pkg::*;

  typedef struct packed {
    logic       pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
    logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src;
    logic       reg_write;
    logic [3:0] state;
    logic       illegal, timeout;
  } obs_t;

  logic clk = 1'b0, rst, mem_ready;
  logic [6:0] opcode;
  logic pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write, illegal, timeout;
  logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic nj_pcw, nj_pcwc, nj_irw, nj_iord, nj_mr, nj_mw, nj_rw, nj_ill, nj_to;
  logic [1:0] nj_m2r, nj_sa, nj_sb, nj_op, nj_ps;
  logic [3:0] nj_state;

  obs_t obs;
  obs_t sb[$];
  int total = 0, bad = 0, step = 0;

  always #5 clk = ~clk;

  multicycle_control #(.SUPPORT_IMM(1), .SUPPORT_JUMP(1), .MEM_TIMEOUT(5), .TW(8)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .reg_write(reg_write),
    .state(state), .illegal(illegal), .timeout(timeout));

  multicycle_control #(.SUPPORT_IMM(0), .SUPPORT_JUMP(0), .MEM_TIMEOUT(0), .TW(8)) u_nj (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(nj_pcw), .pc_write_cond(nj_pcwc), .ir_write(nj_irw), .iord(nj_iord),
    .mem_read(nj_mr), .mem_write(nj_mw), .mem_to_reg(nj_m2r), .alu_src_a(nj_sa),
    .alu_src_b(nj_sb), .alu_op(nj_op), .pc_src(nj_ps), .reg_write(nj_rw),
    .state(nj_state), .illegal(nj_ill), .timeout(nj_to));

  assign obs = {pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, pc_src, reg_write, state, illegal, timeout};

  function automatic obs_t spec_out(input state_t s, input logic rdy, input logic lui);
    obs_t e;
    e = '0;
    e.state = s;
    case (s)
      ST_FETCH:    begin e.mem_read = 1; e.alu_src_b = 1; if (rdy) begin e.ir_write = 1; e.pc_write = 1; end end
      ST_DECODE:   e.alu_src_b = 2;
      ST_EXEC_R:   begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      ST_EXEC_I:   begin e.alu_src_b = 2; e.alu_op = 2'b11; e.alu_src_a = lui ? 2'd2 : 2'd1; end
      ST_WB_ALU:   e.reg_write = 1;
      ST_MEM_ADDR: begin e.alu_src_a = 1; e.alu_src_b = 2; end
      ST_MEM_RD:   begin e.iord = 1; e.mem_read = 1; end
      ST_MEM_WR:   begin e.iord = 1; e.mem_write = 1; end
      ST_WB_MEM:   begin e.reg_write = 1; e.mem_to_reg = 1; end
      ST_BRANCH:   begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_src = 1; end
      ST_JUMP:     begin e.pc_write = 1; e.pc_src = 1; e.reg_write = 1; e.mem_to_reg = 2; end
      ST_JALR:     begin e.alu_src_a = 1; e.alu_src_b = 2; e.pc_write = 1; e.pc_src = 2; e.reg_write = 1; e.mem_to_reg = 2; end
      default:     ;
    endcase
    return e;
  endfunction

  function automatic obs_t quiet(input state_t s, input logic ill, input logic to);
    obs_t e;
    e = '0;
    e.state = s;
    e.illegal = ill;
    e.timeout = to;
    return e;
  endfunction

  task automatic chk(input string tag);
    obs_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s scoreboard empty got=%h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s got=%h exp=%h", tag, obs, e);
      end
    end
  endtask

  task automatic cyc(input logic rdy, input logic [6:0] op, input obs_t e);
    mem_ready = rdy;
    opcode = op;
    sb.push_back(e);
    step++;
    @(negedge clk);
    chk($sformatf("step%0d", step));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    opcode = 7'd0;
    #1;
    sb.push_back(quiet(ST_FETCH, 0, 0));
    chk("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // R-type, zero wait
    cyc(1, OP_R, spec_out(ST_FETCH, 1, 0));
    cyc(1, OP_R, spec_out(ST_DECODE, 1, 0));
    cyc(1, OP_R, spec_out(ST_EXEC_R, 1, 0));
    cyc(1, OP_R, spec_out(ST_WB_ALU, 1, 0));

    // load with three wait cycles in MEM_RD
    cyc(1, OP_LOAD, spec_out(ST_FETCH, 1, 0));
    cyc(1, OP_LOAD, spec_out(ST_DECODE, 1, 0));
    cyc(1, OP_LOAD, spec_out(ST_MEM_ADDR, 1, 0));
    for (int i = 0; i < 3; i++) cyc(0, OP_LOAD, spec_out(ST_MEM_RD, 0, 0));
    cyc(1, OP_LOAD, spec_out(ST_MEM_RD, 1, 0));
    cyc(1, OP_LOAD, spec_out(ST_WB_MEM, 1, 0));

    // store: live opcode flips to R-type after DECODE; ready on the limit cycle
    cyc(1, OP_STORE, spec_out(ST_FETCH, 1, 0));
    cyc(1, OP_STORE, spec_out(ST_DECODE, 1, 0));
    cyc(1, OP_R, spec_out(ST_MEM_ADDR, 1, 0));
    for (int i = 0; i < 4; i++) cyc(0, OP_R, spec_out(ST_MEM_WR, 0, 0));
    cyc(1, OP_R, spec_out(ST_MEM_WR, 1, 0));

    cyc(1, OP_BRANCH, spec_out(ST_FETCH, 1, 0));
    cyc(1, OP_BRANCH, spec_out(ST_DECODE, 1, 0));
    cyc(1, OP_BRANCH, spec_out(ST_BRANCH, 1, 0));

    cyc(1, OP_JAL, spec_out(ST_FETCH, 1, 0));
    cyc(1, OP_JAL, spec_out(ST_DECODE, 1, 0));
    cyc(1, OP_JAL, spec_out(ST_JUMP, 1, 0));

    cyc(1, OP_JALR, spec_out(ST_FETCH, 1, 0));
    cyc(1, OP_JALR, spec_out(ST_DECODE, 1, 0));
    cyc(1, OP_JALR, spec_out(ST_JALR, 1, 0));

    cyc(1, OP_LUI, spec_out(ST_FETCH, 1, 0));
    cyc(1, OP_LUI, spec_out(ST_DECODE, 1, 0));
    cyc(1, OP_IMM, spec_out(ST_EXEC_I, 1, 1));
    cyc(1, OP_IMM, spec_out(ST_WB_ALU, 1, 0));

    cyc(1, OP_IMM, spec_out(ST_FETCH, 1, 0));
    cyc(1, OP_IMM, spec_out(ST_DECODE, 1, 0));
    cyc(1, OP_LUI, spec_out(ST_EXEC_I, 1, 0));
    cyc(1, OP_LUI, spec_out(ST_WB_ALU, 1, 0));

    // illegal opcode traps and the flag holds
    cyc(1, 7'b0000000, spec_out(ST_FETCH, 1, 0));
    cyc(1, 7'b0000000, spec_out(ST_DECODE, 1, 0));
    cyc(1, OP_R, quiet(ST_TRAP, 1, 0));
    cyc(1, OP_R, quiet(ST_TRAP, 1, 0));

    // JAL on a jump-less build is illegal
    do_reset();
    cyc(1, OP_JAL, spec_out(ST_FETCH, 1, 0));
    cyc(1, OP_JAL, spec_out(ST_DECODE, 1, 0));
    total++;
    assert (nj_state === 4'(ST_TRAP)) else begin
      bad++;
      $error("FAIL nj_state got=%0d exp=%0d", nj_state, 4'(ST_TRAP));
    end
    total++;
    assert ({nj_ill, nj_to, nj_pcw, nj_rw} === 4'b1000) else begin
      bad++;
      $error("FAIL nj_flags got=%b exp=%b", {nj_ill, nj_to, nj_pcw, nj_rw}, 4'b1000);
    end
    cyc(1, OP_R, spec_out(ST_JUMP, 1, 0));

    // reset in the middle of a MEM_WR wait
    cyc(1, OP_STORE, spec_out(ST_FETCH, 1, 0));
    cyc(1, OP_STORE, spec_out(ST_DECODE, 1, 0));
    cyc(0, OP_STORE, spec_out(ST_MEM_ADDR, 0, 0));
    cyc(0, OP_STORE, spec_out(ST_MEM_WR, 0, 0));
    rst = 1'b1;
    #1;
    sb.push_back(quiet(ST_FETCH, 0, 0));
    chk("rst_mid_access");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // fresh counter: ready on the limit cycle completes the fetch
    for (int i = 0; i < 4; i++) cyc(0, OP_R, spec_out(ST_FETCH, 0, 0));
    cyc(1, OP_R, spec_out(ST_FETCH, 1, 0));
    cyc(1, OP_R, spec_out(ST_DECODE, 1, 0));
    cyc(1, OP_R, spec_out(ST_EXEC_R, 1, 0));
    cyc(1, OP_R, spec_out(ST_WB_ALU, 1, 0));

    // fetch timeout after five wait cycles
    for (int i = 0; i < 5; i++) cyc(0, OP_R, spec_out(ST_FETCH, 0, 0));
    cyc(1, OP_R, quiet(ST_TRAP, 0, 1));
    cyc(1, OP_R, quiet(ST_TRAP, 0, 1));
    cyc(0, OP_R, quiet(ST_TRAP, 0, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
